// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serialising memory arbiter.
// Holds FSM encoding, requester IDs, lane/step widths and read latency.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_ME = 1'b1
    } req_e;

    localparam int BYTE_CNT_W = 2;
    typedef logic [BYTE_CNT_W-1:0] lane_t;

    // External RAM returns data this many cycles after the address is driven.
    localparam int READ_LAT = 1;

    typedef logic [2:0] step_t;
    localparam step_t RD_LAT_STEP  = step_t'(READ_LAT);
    localparam step_t RD_ADDR_LAST = step_t'(3);
    localparam step_t RD_LAST_STEP = step_t'(3 + READ_LAT);

    function automatic lane_t first_lane(input logic [3:0] mask);
        lane_t lane;
        lane = '0;
        for (int k = 3; k >= 0; k--) begin
            if (mask[k]) lane = lane_t'(k);
        end
        return lane;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input lane_t lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_mask_scan.sv
// Combinational lane scanner: finds the next set mask bit above the current lane
// and flags when the current lane is the last one to be written.
module mem_mask_scan
    import mem_arbiter_pkg::*;
(
    input  logic [3:0]            mask_i,
    input  logic [BYTE_CNT_W-1:0] lane_i,
    output logic [BYTE_CNT_W-1:0] next_lane_o,
    output logic                  last_o
);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        next_lane_o = lane_i;
        last_o      = 1'b1;
        // Descending walk so the lowest qualifying lane is the one that sticks.
        for (int k = 3; k >= 0; k--) begin
            if (k > int'(lane_i) && mask_i[k]) begin
                next_lane_o = lane_t'(k);
                last_o      = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between IF (read) and ME (load/store), serialising words into bytes.
// Define MEM_ARBITER_ROUND_ROBIN_EN to alternate grants on IF/ME ties instead of fixed ME priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_r_enable,
    input  logic [31:0]               if_addr,
    output logic [31:0]               if_data,
    output logic                      if_busy,
    output logic                      if_done,
    input  logic                      me_r_enable,
    input  logic                      me_w_enable,
    input  logic [3:0]                me_w_mask,
    input  logic [31:0]               me_w_data,
    input  logic [31:0]               me_addr,
    output logic [31:0]               me_r_data,
    output logic                      me_busy,
    output logic                      me_done,
    output logic [MEM_ADDR_WIDTH-1:0] mem_a,
    output logic                      mem_wr,
    output logic [7:0]                mem_dout,
    input  logic [7:0]                mem_din
);

    localparam int WORD_W = MEM_ADDR_WIDTH - 2;

    state_e                    state_q, state_d;
    req_e                      owner_q, owner_d;
    logic [WORD_W-1:0]         word_q, word_d;
    logic [3:0]                mask_q, mask_d;
    logic [31:0]               wdata_q, wdata_d;
    lane_t                     lane_q, lane_d;
    step_t                     step_q, step_d;
    logic [31:0]               rd_word_q, rd_word_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]                mem_dout_q, mem_dout_d;
    logic [31:0]               if_data_q, if_data_d;
    logic [31:0]               me_data_q, me_data_d;

    logic  me_req;
    logic  grant_me;
    lane_t scan_next;
    logic  scan_last;
    lane_t cap_lane;

    // Word-aligned request addresses keep only the in-range word index.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:MEM_ADDR_WIDTH], if_addr[1:0],
                                me_addr[31:MEM_ADDR_WIDTH], me_addr[1:0]};

    assign me_req = me_r_enable | me_w_enable;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    req_e last_q, last_d;
    assign grant_me = me_req && (!if_r_enable || last_q == REQ_IF);
`else
    assign grant_me = me_req;
`endif

    mem_mask_scan u_scan (
        .mask_i      (mask_q),
        .lane_i      (lane_q),
        .next_lane_o (scan_next),
        .last_o      (scan_last)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        word_d     = word_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        lane_d     = lane_q;
        step_d     = step_q;
        rd_word_d  = rd_word_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        if_data_d  = if_data_q;
        me_data_d  = me_data_q;
        cap_lane   = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_me) begin
                    owner_d = REQ_ME;
                    word_d  = me_addr[MEM_ADDR_WIDTH-1:2];
                    if (me_w_enable) begin
                        mask_d  = me_w_mask;
                        wdata_d = me_w_data;
                        if (me_w_mask == 4'b0000) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d    = ST_WR;
                            lane_d     = first_lane(me_w_mask);
                            mem_a_d    = {me_addr[MEM_ADDR_WIDTH-1:2], lane_d};
                            mem_dout_d = lane_byte(me_w_data, lane_d);
                        end
                    end else begin
                        state_d = ST_RD;
                        step_d  = '0;
                        mem_a_d = {me_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
                    end
                end else if (if_r_enable) begin
                    owner_d = REQ_IF;
                    word_d  = if_addr[MEM_ADDR_WIDTH-1:2];
                    state_d = ST_RD;
                    step_d  = '0;
                    mem_a_d = {if_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
                end
            end

            ST_RD: begin
                step_d = step_q + step_t'(1);
                if (step_q < RD_ADDR_LAST) mem_a_d = {word_q, step_d[1:0]};
                // Capture trails the address by READ_LAT cycles.
                if (step_q >= RD_LAT_STEP) begin
                    cap_lane = lane_t'(step_q - RD_LAT_STEP);
                    rd_word_d[{cap_lane, 3'b000} +: 8] = mem_din;
                end
                if (step_q == RD_LAST_STEP) begin
                    state_d = ST_DONE;
                    if (owner_q == REQ_IF) if_data_d = rd_word_d;
                    else                   me_data_d = rd_word_d;
                end
            end

            ST_WR: begin
                if (scan_last) begin
                    state_d = ST_DONE;
                end else begin
                    lane_d     = scan_next;
                    mem_a_d    = {word_q, scan_next};
                    mem_dout_d = lane_byte(wdata_q, scan_next);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    always_comb begin
        last_d = last_q;
        if (state_q == ST_IDLE && state_d != ST_IDLE) last_d = owner_d;
    end
`endif

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= REQ_IF;
            word_q     <= '0;
            mask_q     <= '0;
            wdata_q    <= '0;
            lane_q     <= '0;
            step_q     <= '0;
            rd_word_q  <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            if_data_q  <= '0;
            me_data_q  <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_q     <= REQ_IF;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            word_q     <= word_d;
            mask_q     <= mask_d;
            wdata_q    <= wdata_d;
            lane_q     <= lane_d;
            step_q     <= step_d;
            rd_word_q  <= rd_word_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            if_data_q  <= if_data_d;
            me_data_q  <= me_data_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign if_done   = (state_q == ST_DONE) && (owner_q == REQ_IF);
    assign me_done   = (state_q == ST_DONE) && (owner_q == REQ_ME);
    assign if_busy   = (state_q != ST_IDLE) && !if_done;
    assign me_busy   = (state_q != ST_IDLE) && !me_done;
    assign if_data   = if_data_q;
    assign me_r_data = me_data_q;
    assign mem_a     = mem_a_q;
    assign mem_wr    = (state_q == ST_WR);
    assign mem_dout  = mem_dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model (data one cycle after address).
// Expectations follow the cycle numbering where cycle 0 is the IDLE acceptance cycle.
module tb_mem_arbiter;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_r_enable;
    logic [31:0]   if_addr;
    logic [31:0]   if_data;
    logic          if_busy;
    logic          if_done;
    logic          me_r_enable;
    logic          me_w_enable;
    logic [3:0]    me_w_mask;
    logic [31:0]   me_w_data;
    logic [31:0]   me_addr;
    logic [31:0]   me_r_data;
    logic          me_busy;
    logic          me_done;
    logic [AW-1:0] mem_a;
    logic          mem_wr;
    logic [7:0]    mem_dout;
    logic [7:0]    mem_din;

    logic [7:0]    ram [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [7:0]    pl_data;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    mem_arbiter #(.MEM_ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_r_enable (if_r_enable),
        .if_addr     (if_addr),
        .if_data     (if_data),
        .if_busy     (if_busy),
        .if_done     (if_done),
        .me_r_enable (me_r_enable),
        .me_w_enable (me_w_enable),
        .me_w_mask   (me_w_mask),
        .me_w_data   (me_w_data),
        .me_addr     (me_addr),
        .me_r_data   (me_r_data),
        .me_busy     (me_busy),
        .me_done     (me_done),
        .mem_a       (mem_a),
        .mem_wr      (mem_wr),
        .mem_dout    (mem_dout),
        .mem_din     (mem_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_din <= ram[mem_a];
        if (pl_en)       ram[pl_addr] <= pl_data;
        else if (mem_wr) ram[mem_a]   <= mem_dout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        int done_cnt;
        int done_cyc;
        logic busy7;

        rst = 1'b1;
        if_r_enable = 1'b0; if_addr = '0;
        me_r_enable = 1'b0; me_w_enable = 1'b0; me_w_mask = '0; me_w_data = '0; me_addr = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        preload(17'h104, 8'h13); preload(17'h105, 8'h05); preload(17'h106, 8'h10); preload(17'h107, 8'h00);
        preload(17'h200, 8'h11); preload(17'h201, 8'h22); preload(17'h202, 8'h33); preload(17'h203, 8'h44);
        preload(17'h300, 8'h01); preload(17'h301, 8'h02); preload(17'h302, 8'h03); preload(17'h303, 8'h04);
        preload(17'h400, 8'h00); preload(17'h401, 8'h00); preload(17'h402, 8'h00); preload(17'h403, 8'h00);
        tick();

        // Reset state
        check("rst_mem_a", 32'(mem_a), 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        check("rst_mem_dout", 32'(mem_dout), 32'h0);
        check("rst_if_busy", 32'(if_busy), 32'h0);
        check("rst_me_busy", 32'(me_busy), 32'h0);
        check("rst_if_done", 32'(if_done), 32'h0);
        check("rst_me_done", 32'(me_done), 32'h0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_me_r_data", me_r_data, 32'h0);
        rst = 1'b0;
        tick();

        // IF read of 0x104
        if_addr = 32'h0000_0104; if_r_enable = 1'b1;
        check("t1_if_busy_c0", 32'(if_busy), 32'h0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("t1_mem_a", 32'(mem_a), 32'h104 + 32'(c) - 32'h1);
            check("t1_mem_wr", 32'(mem_wr), 32'h0);
            check("t1_if_busy", 32'(if_busy), 32'h1);
        end
        tick();
        check("t1_if_done_c5", 32'(if_done), 32'h0);
        tick();
        check("t1_if_done_c6", 32'(if_done), 32'h1);
        check("t1_if_data", if_data, 32'h0010_0513);
        check("t1_if_busy_done", 32'(if_busy), 32'h0);
        check("t1_me_busy_done", 32'(me_busy), 32'h1);
        if_r_enable = 1'b0;
        tick();
        check("t1_if_done_c7", 32'(if_done), 32'h0);
        check("t1_if_data_hold", if_data, 32'h0010_0513);
        check("t1_if_busy_idle", 32'(if_busy), 32'h0);

        // ME store, single lane 3
        me_addr = 32'h0000_0203; me_w_mask = 4'b1000; me_w_data = 32'hAB00_0000; me_w_enable = 1'b1;
        tick();
        check("t2_mem_wr_c1", 32'(mem_wr), 32'h1);
        check("t2_mem_a_c1", 32'(mem_a), 32'h203);
        check("t2_mem_dout_c1", 32'(mem_dout), 32'hAB);
        check("t2_me_busy_c1", 32'(me_busy), 32'h1);
        check("t2_if_busy_c1", 32'(if_busy), 32'h1);
        me_w_enable = 1'b0;
        tick();
        check("t2_me_done_c2", 32'(me_done), 32'h1);
        check("t2_mem_wr_c2", 32'(mem_wr), 32'h0);
        check("t2_me_busy_c2", 32'(me_busy), 32'h0);
        tick();
        check("t2_me_done_c3", 32'(me_done), 32'h0);
        check("t2_ram_203", 32'(ram[17'h203]), 32'hAB);
        check("t2_ram_200", 32'(ram[17'h200]), 32'h11);
        check("t2_ram_201", 32'(ram[17'h201]), 32'h22);
        check("t2_ram_202", 32'(ram[17'h202]), 32'h33);
        check("t2_me_r_data_untouched", me_r_data, 32'h0);

        // ME store, mask 0101 then mask 0000
        me_addr = 32'h0000_0300; me_w_mask = 4'b0101; me_w_data = 32'h00CC_00DD; me_w_enable = 1'b1;
        tick();
        check("t3_mem_wr_c1", 32'(mem_wr), 32'h1);
        check("t3_mem_a_c1", 32'(mem_a), 32'h300);
        check("t3_mem_dout_c1", 32'(mem_dout), 32'hDD);
        me_w_enable = 1'b0;
        tick();
        check("t3_mem_wr_c2", 32'(mem_wr), 32'h1);
        check("t3_mem_a_c2", 32'(mem_a), 32'h302);
        check("t3_mem_dout_c2", 32'(mem_dout), 32'hCC);
        check("t3_me_done_c2", 32'(me_done), 32'h0);
        tick();
        check("t3_me_done_c3", 32'(me_done), 32'h1);
        check("t3_mem_wr_c3", 32'(mem_wr), 32'h0);
        tick();
        check("t3_ram_300", 32'(ram[17'h300]), 32'hDD);
        check("t3_ram_301", 32'(ram[17'h301]), 32'h02);
        check("t3_ram_302", 32'(ram[17'h302]), 32'hCC);
        check("t3_ram_303", 32'(ram[17'h303]), 32'h04);
        me_addr = 32'h0000_0310; me_w_mask = 4'b0000; me_w_enable = 1'b1;
        tick();
        check("t3z_me_done_c1", 32'(me_done), 32'h1);
        check("t3z_mem_wr_c1", 32'(mem_wr), 32'h0);
        check("t3z_mem_a_hold", 32'(mem_a), 32'h302);
        me_w_enable = 1'b0;
        tick();
        check("t3z_me_done_c2", 32'(me_done), 32'h0);

        // ME load held through done: one pulse, re-accepted after DONE
        me_addr = 32'h0000_0300; me_r_enable = 1'b1;
        done_cnt = 0; done_cyc = 0; busy7 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (me_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c == 6) check("t6_me_r_data", me_r_data, 32'h04CC_02DD);
            if (c == 7) busy7 = me_busy;
        end
        check("t6_done_count", 32'(done_cnt), 32'h1);
        check("t6_done_cycle", 32'(done_cyc), 32'h6);
        check("t6_busy_idle_c7", 32'(busy7), 32'h0);
        check("t6_reaccept_mem_a", 32'(mem_a), 32'h300);
        check("t6_reaccept_busy", 32'(me_busy), 32'h1);
        me_r_enable = 1'b0;
        repeat (5) tick();
        check("t6_second_done", 32'(me_done), 32'h1);
        tick();

        // Reset during a 4-byte store
        me_addr = 32'h0000_0400; me_w_mask = 4'b1111; me_w_data = 32'h4433_2211; me_w_enable = 1'b1;
        tick();
        check("t5_mem_a_c1", 32'(mem_a), 32'h400);
        check("t5_mem_wr_c1", 32'(mem_wr), 32'h1);
        tick();
        check("t5_mem_a_c2", 32'(mem_a), 32'h401);
        check("t5_mem_dout_c2", 32'(mem_dout), 32'h22);
        rst = 1'b1; me_w_enable = 1'b0;
        tick();
        check("t5_mem_wr_rst", 32'(mem_wr), 32'h0);
        check("t5_mem_a_rst", 32'(mem_a), 32'h0);
        check("t5_mem_dout_rst", 32'(mem_dout), 32'h0);
        check("t5_me_done_rst", 32'(me_done), 32'h0);
        check("t5_me_busy_rst", 32'(me_busy), 32'h0);
        check("t5_if_data_rst", if_data, 32'h0);
        check("t5_me_r_data_rst", me_r_data, 32'h0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t5_no_done", 32'(me_done), 32'h0);
            check("t5_no_wr", 32'(mem_wr), 32'h0);
        end
        check("t5_ram_400", 32'(ram[17'h400]), 32'h11);
        check("t5_ram_401", 32'(ram[17'h401]), 32'h22);
        check("t5_ram_402", 32'(ram[17'h402]), 32'h00);
        check("t5_ram_403", 32'(ram[17'h403]), 32'h00);
        if_addr = 32'h0000_0104; if_r_enable = 1'b1;
        tick();
        check("t5_new_mem_a", 32'(mem_a), 32'h104);
        check("t5_new_if_busy", 32'(if_busy), 32'h1);
        repeat (5) tick();
        check("t5_new_if_done", 32'(if_done), 32'h1);
        check("t5_new_if_data", if_data, 32'h0010_0513);
        if_r_enable = 1'b0;
        tick();

        // Simultaneous IF and ME requests
        if_addr = 32'h0000_0104; if_r_enable = 1'b1;
        me_addr = 32'h0000_0200; me_r_enable = 1'b1;
        tick();
        check("t4_me_first_mem_a", 32'(mem_a), 32'h200);
        check("t4_if_busy_c1", 32'(if_busy), 32'h1);
        check("t4_me_busy_c1", 32'(me_busy), 32'h1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            check("t4_if_busy_rd", 32'(if_busy), 32'h1);
        end
        tick();
        check("t4_me_done_c6", 32'(me_done), 32'h1);
        check("t4_me_r_data", me_r_data, 32'hAB33_2211);
        check("t4_if_busy_c6", 32'(if_busy), 32'h1);
        check("t4_me_busy_c6", 32'(me_busy), 32'h0);
        me_r_enable = 1'b0;
        tick();
        check("t4_if_busy_c7", 32'(if_busy), 32'h0);
        check("t4_if_done_c7", 32'(if_done), 32'h0);
        tick();
        check("t4_if_mem_a_c8", 32'(mem_a), 32'h104);
        check("t4_if_busy_c8", 32'(if_busy), 32'h1);
        repeat (4) tick();
        check("t4_if_done_c12", 32'(if_done), 32'h0);
        tick();
        check("t4_if_done_c13", 32'(if_done), 32'h1);
        check("t4_if_data", if_data, 32'h0010_0513);
        if_r_enable = 1'b0;
        tick();

        // Two back-to-back ties: second grant depends on the arbitration policy
        if_addr = 32'h0000_0104; if_r_enable = 1'b1;
        me_addr = 32'h0000_0300; me_r_enable = 1'b1;
        tick();
        check("t4b_first_mem_a", 32'(mem_a), 32'h300);
        repeat (5) tick();
        check("t4b_me_done_c6", 32'(me_done), 32'h1);
        check("t4b_me_r_data", me_r_data, 32'h04CC_02DD);
        tick();
        tick();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        check("t4b_rr_grant", 32'(mem_a), 32'h104);
`else
        check("t4b_fixed_grant", 32'(mem_a), 32'h300);
`endif
        if_r_enable = 1'b0; me_r_enable = 1'b0;
        repeat (5) tick();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        check("t4b_rr_if_done", 32'(if_done), 32'h1);
`else
        check("t4b_fixed_me_done", 32'(me_done), 32'h1);
`endif
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide external RAM port between instruction fetch (IF, read-only) and the memory stage (ME, load/store).
- Serialises each 32-bit request into byte accesses and reassembles read data.
- Drives per-requester busy/done so that ME and IF stall until their access completes.
- Sits between the pipeline stages and the top-level RAM pins.

Parameters:
MEM_ADDR_WIDTH, 17, width of external byte address; request address truncated to this width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
if_r_enable  in  1  IF read request, held until if_done
if_addr  in  32  IF word address; bits [1:0] ignored
if_data  out  32  fetched word, valid while if_done=1
if_busy  out  1  arbiter cannot accept IF request
if_done  out  1  one-cycle IF completion pulse
me_r_enable  in  1  ME load request
me_w_enable  in  1  ME store request; wins over me_r_enable if both set
me_w_mask  in  4  byte-lane enables for stores, bit k = byte k
me_w_data  in  32  store data, lane k = bits [8k+7:8k]
me_addr  in  32  ME address; bits [1:0] ignored
me_r_data  out  32  loaded word, valid while me_done=1
me_busy  out  1  arbiter cannot accept ME request
me_done  out  1  one-cycle ME completion pulse
mem_a  out  MEM_ADDR_WIDTH  external byte address
mem_wr  out  1  external write strobe
mem_dout  out  8  external write data
mem_din  in  8  external read data, valid one cycle after address

Behaviour:
- States: IDLE, RD, WR, DONE. Requests are accepted only in IDLE.
- Reset: state=IDLE, all outputs 0 (mem_a=0, mem_wr=0, busy=0, done=0, data=0). Reset mid-operation aborts the access with no done pulse; no further mem_wr strobes are issued.
- Arbitration in IDLE: ME has priority over IF. The request word address {addr[31:2],2'b00}, the mask and the write data are latched at acceptance (cycle 0).
- Read (RD):
  - Cycles 1–4 drive mem_a = base+0..3 with mem_wr=0.
  - mem_din is captured in cycles 2–5 into byte lanes 0–3.
  - DONE in cycle 6: requester's done=1 and data=assembled word. IDLE in cycle 7.
- Write (WR):
  - Visits only the set mask bits, ascending, one per cycle, from cycle 1.
  - Each visit: mem_a = base+k, mem_wr=1, mem_dout = lane k.
  - DONE follows the last write. With n set bits, done occurs in cycle n+1.
  - Mask 0000: no strobe, done in cycle 1.
- busy:
  - Both 0 in IDLE.
  - Otherwise, busy=1 for any requester not currently receiving done. The served requester's busy=1 during RD/WR and 0 in its DONE cycle.
- done/data are Moore outputs from registered state. Data holds its last value after the done cycle.
- Withdrawal: a request dropped mid-access still completes, and done still pulses.
- mem_a holds its last value when idle; mem_wr=0 whenever not in WR.
- Request high in the DONE cycle is not accepted until the following IDLE cycle (one-cycle bubble is mandatory).

Optional Feature:
MEM_ARBITER_ROUND_ROBIN_EN
- Defined: on simultaneous IF and ME requests in IDLE, the grant goes to the requester not served last. A 1-bit last-grant register is reset to IF, so ME wins the first tie.
- Undefined: fixed ME priority, no last-grant register.

Decomposition:
- Package mem_arbiter_pkg holds:
  - state encoding (IDLE/RD/WR/DONE, 2 bits)
  - requester ID constants (REQ_IF, REQ_ME)
  - byte-count width (2 bits)
  - the READ_LAT=1 constant
- Sub-module mem_mask_scan (combinational): given a 4-bit mask and current lane, returns the next set lane and a last flag. It is used by WR for skipping lanes.

Test Plan:
1. IF read of 0x00000104 with RAM bytes 0x13,0x05,0x10,0x00 at 0x104–0x107 -> mem_a 0x104..0x107 in cycles 1–4, if_done in cycle 6, if_data=0x00100513.
2. ME store, addr 0x203, mask 1000, data 0xAB000000 -> single mem_wr with mem_a=0x203, mem_dout=0xAB, me_done in cycle 2; bytes 0x200–0x202 untouched.
3. ME store, mask 0101, data 0x00CC00DD at 0x300 -> writes 0x300=0xDD then 0x302=0xCC, done in cycle 3; mask 0000 -> no strobe, done in cycle 1.
4. IF and ME raise requests in the same cycle -> ME served first with if_busy=1 throughout; IF accepted in the IDLE cycle after me_done. With ROUND_ROBIN_EN and a second tie, IF wins.
5. rst asserted in cycle 2 of a 4-byte store -> no mem_wr from the next cycle, no me_done, all outputs 0, IDLE accepts a new request after rst falls.
6. ME load holding me_r_enable through me_done -> exactly one done pulse, re-acceptance no earlier than the cycle after DONE.
